// File: rtl/prog_bus_master.sv
// Programmable bus master: replays a host-loaded 256-entry transaction list over a Req/Ack,
// Ready-paced bus. Define PROG_MASTER_READBACK_EN to write read results back into the program.
module prog_bus_master #(
  parameter int unsigned DELAY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        Prog,
  input  logic [31:0] ProgAddress,
  input  logic [31:0] ProgData,
  input  logic [6:0]  ProgControl,
  output logic [8:0]  EControl,
  output logic [31:0] EAddress,
  output logic [31:0] EWData,
  output logic        Req,
  input  logic        Ack,
  input  logic        Ready,
  input  logic [31:0] RData
);

  localparam int unsigned GapCycles = (DELAY == 0) ? 1 : DELAY;
  localparam logic [6:0]  EndMarker = 7'h7F;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StXfer  = 2'd2,
    StGap   = 2'd3
  } state_e;

  state_e      pstate_q, pstate_d;
  logic        busy_q, busy_d;
  logic [7:0]  mem_index_q, mem_index_d;
  logic [4:0]  burst_q, burst_d;
  logic [15:0] gap_q, gap_d;
  logic [7:0]  wptr_q, wptr_d;
  logic        req_q, req_d;
  logic [1:0]  status_q, status_d;
  logic [6:0]  ectrl_q, ectrl_d;
  logic [31:0] eaddr_q, eaddr_d;
  logic [31:0] ewdata_q, ewdata_d;
  logic [31:0] last_rdata_q, last_rdata_d;
  logic        load;

  // Entry layout: {control[6:0], address[31:0], data[31:0]}; contents survive reset.
  logic [70:0] mem [256];
  logic [7:0]  rd_idx;
  logic [70:0] rd_entry;
  logic [6:0]  rd_ctrl;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic        prog_we;

  // IDLE only ever looks at entry 0; GAP looks ahead to the next entry.
  assign rd_idx   = (pstate_q == StGap) ? mem_index_q + 8'd1 : 8'd0;
  assign rd_entry = mem[rd_idx];
  assign rd_ctrl  = rd_entry[70:64];
  assign rd_addr  = rd_entry[63:32];
  assign rd_data  = rd_entry[31:0];

  assign prog_we = Prog && !busy_q && !reset;
  assign wptr_d  = prog_we ? wptr_q + 8'd1 : wptr_q;

`ifdef PROG_MASTER_READBACK_EN
  logic rb_we;
  assign rb_we = (pstate_q == StXfer) && Ack && Ready && !ectrl_q[0] && (burst_q == 5'd1);
`endif

  always_ff @(posedge clk) begin
    if (prog_we) mem[wptr_q] <= {ProgControl, ProgAddress, ProgData};
`ifdef PROG_MASTER_READBACK_EN
    if (rb_we) mem[mem_index_q][31:0] <= RData;
`endif
  end

  always_comb begin
    pstate_d     = pstate_q;
    busy_d       = busy_q;
    mem_index_d  = mem_index_q;
    burst_d      = burst_q;
    gap_d        = gap_q;
    req_d        = req_q;
    status_d     = status_q;
    ectrl_d      = ectrl_q;
    eaddr_d      = eaddr_q;
    ewdata_d     = ewdata_q;
    last_rdata_d = last_rdata_q;
    load         = 1'b0;

    case (pstate_q)
      StIdle: begin
        if (en) begin
          mem_index_d = 8'd0;
          if (rd_ctrl == EndMarker) begin
            busy_d = 1'b0;
          end else begin
            busy_d   = 1'b1;
            load     = 1'b1;
            pstate_d = StFetch;
          end
        end
      end
      StFetch: begin
        if (Ack) begin
          status_d = 2'b01;
          pstate_d = StXfer;
        end
      end
      StXfer: begin
        // A beat needs both the grant and the slave's Ready.
        if (Ack && Ready) begin
          eaddr_d  = eaddr_q + (32'd1 << ectrl_q[2:1]);
          burst_d  = burst_q - 5'd1;
          status_d = 2'b10;
          if (!ectrl_q[0]) last_rdata_d = RData;
          if (burst_q == 5'd1) begin
            req_d    = 1'b0;
            status_d = 2'b00;
            gap_d    = 16'd0;
            pstate_d = StGap;
          end
        end
      end
      StGap: begin
        if (gap_q == 16'(GapCycles - 1)) begin
          mem_index_d = mem_index_q + 8'd1;
          if (rd_ctrl == EndMarker || mem_index_d == 8'd0) begin
            busy_d   = 1'b0;
            pstate_d = StIdle;
          end else begin
            load     = 1'b1;
            pstate_d = StFetch;
          end
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      default: pstate_d = StIdle;
    endcase

    if (load) begin
      eaddr_d  = rd_addr;
      ewdata_d = rd_data;
      ectrl_d  = rd_ctrl;
      burst_d  = {1'b0, rd_ctrl[6:3]} + 5'd1;
      req_d    = 1'b1;
      status_d = 2'b11;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pstate_q     <= StIdle;
      busy_q       <= 1'b0;
      mem_index_q  <= 8'd0;
      burst_q      <= 5'd0;
      gap_q        <= 16'd0;
      wptr_q       <= 8'd0;
      req_q        <= 1'b0;
      status_q     <= 2'b00;
      ectrl_q      <= 7'd0;
      eaddr_q      <= 32'd0;
      ewdata_q     <= 32'd0;
      last_rdata_q <= 32'd0;
    end else begin
      pstate_q     <= pstate_d;
      busy_q       <= busy_d;
      mem_index_q  <= mem_index_d;
      burst_q      <= burst_d;
      gap_q        <= gap_d;
      wptr_q       <= wptr_d;
      req_q        <= req_d;
      status_q     <= status_d;
      ectrl_q      <= ectrl_d;
      eaddr_q      <= eaddr_d;
      ewdata_q     <= ewdata_d;
      last_rdata_q <= last_rdata_d;
    end
  end

  assign Req      = req_q;
  assign EControl = {status_q, ectrl_q};
  assign EAddress = eaddr_q;
  assign EWData   = ewdata_q;

endmodule

// File: tb/tb_prog_bus_master.sv
// Bench for prog_bus_master: expected beats are queued as the program is loaded and
// checked against every completed bus beat.
module tb_prog_bus_master;

  localparam int unsigned Delay = 2;
  localparam int unsigned Gap   = (Delay == 0) ? 1 : Delay;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic        Prog = 1'b0;
  logic [31:0] ProgAddress = '0;
  logic [31:0] ProgData = '0;
  logic [6:0]  ProgControl = '0;
  logic [8:0]  EControl;
  logic [31:0] EAddress;
  logic [31:0] EWData;
  logic        Req;
  logic        Ack = 1'b0;
  logic        Ready = 1'b0;
  logic [31:0] RData;

  prog_bus_master #(.DELAY(Delay)) dut (
    .clk(clk), .reset(reset), .en(en), .Prog(Prog), .ProgAddress(ProgAddress),
    .ProgData(ProgData), .ProgControl(ProgControl), .EControl(EControl),
    .EAddress(EAddress), .EWData(EWData), .Req(Req), .Ack(Ack), .Ready(Ready),
    .RData(RData)
  );

  always #5 clk = ~clk;

  // Slave read model keyed by beat address.
  function automatic logic [31:0] slave_rdata(input logic [31:0] a);
    case (a)
      32'h2:    return 32'h0000000B;
      32'h4:    return 32'h00004455;
      32'h1C:   return 32'hCAFEF00D;
      default:  return {16'hBAD0, a[15:0]};
    endcase
  endfunction
  assign RData = slave_rdata(EAddress);

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  st;
    logic [6:0]  ctrl;
  } beat_t;

  beat_t sb[$];
  int total = 0;
  int bad = 0;
  int gap_seen = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_txn(input logic [6:0] c, input logic [31:0] a, input logic [31:0] d);
    beat_t b;
    int n = int'(c[6:3]) + 1;
    logic [31:0] inc = 32'd1 << c[2:1];
    for (int i = 0; i < n; i++) begin
      b.addr  = a + inc * i;
      b.wdata = d;
      b.st    = (i == 0) ? 2'b01 : 2'b10;
      b.ctrl  = c;
      sb.push_back(b);
    end
  endtask

  task automatic prog_entry(input logic [6:0] c, input logic [31:0] a, input logic [31:0] d,
                            input bit expect_run);
    @(posedge clk); #1;
    Prog = 1'b1; ProgControl = c; ProgAddress = a; ProgData = d;
    @(posedge clk); #1;
    Prog = 1'b0;
    if (expect_run) push_txn(c, a, d);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic pulse_en();
    @(posedge clk); #1;
    en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (dut.busy_q && n < 500);
    check_eq(tag, 64'(dut.busy_q), 64'd0);
    check_eq({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
  endtask

  task automatic wait_status(input logic [1:0] st, input string tag);
    int n = 0;
    while (EControl[8:7] != st && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 64'(EControl[8:7]), 64'(st));
  endtask

  // Beat monitor: a beat completes at the next posedge when Req, Ack and Ready are all high.
  always @(negedge clk) begin
    if (!reset && dut.busy_q && !Req) gap_seen++;
    if (!reset && Req && Ack && Ready &&
        (EControl[8:7] == 2'b01 || EControl[8:7] == 2'b10)) begin
      check_eq("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        beat_t e;
        e = sb.pop_front();
        check_eq("beat_addr", 64'(EAddress), 64'(e.addr));
        check_eq("beat_status", 64'(EControl[8:7]), 64'(e.st));
        check_eq("beat_ctrl", 64'(EControl[6:0]), 64'(e.ctrl));
        if (e.ctrl[0]) check_eq("beat_wdata", 64'(EWData), 64'(e.wdata));
      end
    end
  end

  initial begin
    logic [31:0] exp_mem0;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("rst_req", 64'(Req), 64'd0);
    check_eq("rst_econtrol", 64'(EControl), 64'd0);
    check_eq("rst_eaddress", 64'(EAddress), 64'd0);
    check_eq("rst_ewdata", 64'(EWData), 64'd0);
    check_eq("rst_busy", 64'(dut.busy_q), 64'd0);
    check_eq("rst_pstate", 64'(dut.pstate_q), 64'd0);
    check_eq("rst_memindex", 64'(dut.mem_index_q), 64'd0);
    check_eq("rst_burst", 64'(dut.burst_q), 64'd0);
    check_eq("rst_wptr", 64'(dut.wptr_q), 64'd0);
    check_eq("rst_lastrdata", 64'(dut.last_rdata_q), 64'd0);

    // Two byte writes, DELAY idle clocks between them, then the marker.
    prog_entry(7'b0000001, 32'h0, 32'h45, 1'b1);
    prog_entry(7'b0000001, 32'h1, 32'h99, 1'b1);
    prog_entry(7'h7F, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    check_eq("wptr_after_load", 64'(dut.wptr_q), 64'd3);
    do_reset();
    @(negedge clk);
    check_eq("wptr_after_reset", 64'(dut.wptr_q), 64'd0);
    Ack = 1'b1; Ready = 1'b1;
    gap_seen = 0;
    pulse_en();
    wait_idle("t1_done");
    check_eq("t1_gap_clocks", 64'(gap_seen), 64'(2 * Gap));
    check_eq("t1_req_idle", 64'(Req), 64'd0);

    // Half-word read burst of 2 at 0x2.
    do_reset();
    prog_entry(7'b0001010, 32'h2, 32'h0, 1'b1);
    prog_entry(7'h7F, 32'h0, 32'h0, 1'b0);
    pulse_en();
    wait_idle("t2_done");
    check_eq("t2_lastrdata", 64'(dut.last_rdata_q), 64'h4455);
`ifdef PROG_MASTER_READBACK_EN
    exp_mem0 = 32'h4455;
`else
    exp_mem0 = 32'h0;
`endif
    check_eq("t2_mem0_data", 64'(dut.mem[0][31:0]), 64'(exp_mem0));

    // Grant withheld for 3 clocks after FETCH.
    do_reset();
    prog_entry(7'b0000001, 32'h100, 32'hA5, 1'b1);
    prog_entry(7'h7F, 32'h0, 32'h0, 1'b0);
    Ack = 1'b0;
    pulse_en();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("t3_req_wait", 64'(Req), 64'd1);
      check_eq("t3_status_wait", 64'(EControl[8:7]), 64'b11);
      check_eq("t3_addr_wait", 64'(EAddress), 64'h100);
    end
    @(posedge clk); #1;
    Ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("t3_xfer_start", 64'(EControl[8:7]), 64'b01);
    wait_idle("t3_done");

    // Word write burst of 4 with a 4-clock Ready stall after the first beat.
    do_reset();
    prog_entry(7'b0011101, 32'h40, 32'hDEADBEEF, 1'b1);
    prog_entry(7'h7F, 32'h0, 32'h0, 1'b0);
    Ready = 1'b0;
    pulse_en();
    wait_status(2'b01, "t4_reach_xfer");
    @(posedge clk); #1;
    Ready = 1'b1;
    @(posedge clk); #1;
    Ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("t4_addr_frozen", 64'(EAddress), 64'h44);
      check_eq("t4_burst_frozen", 64'(dut.burst_q), 64'd3);
    end
    @(posedge clk); #1;
    Ready = 1'b1;
    wait_idle("t4_done");

    // Dword writes at 0x14/0x18, dword read at 0x1C.
    do_reset();
    prog_entry(7'b0000111, 32'h14, 32'h11111111, 1'b1);
    prog_entry(7'b0000111, 32'h18, 32'h22222222, 1'b1);
    prog_entry(7'b0000110, 32'h1C, 32'h0, 1'b1);
    prog_entry(7'h7F, 32'h0, 32'h0, 1'b0);
    pulse_en();
    wait_idle("t5_done");
    check_eq("t5_lastrdata", 64'(dut.last_rdata_q), 64'hCAFEF00D);
    check_eq("t5_final_addr", 64'(EAddress), 64'h24);
    check_eq("t5_final_econtrol", 64'(EControl), 64'h006);

    // Asynchronous reset in the middle of a burst, then replay from entry 0.
    do_reset();
    prog_entry(7'b0011101, 32'h200, 32'h12345678, 1'b0);
    prog_entry(7'h7F, 32'h0, 32'h0, 1'b0);
    Ready = 1'b0;
    pulse_en();
    wait_status(2'b01, "t6_reach_xfer");
    #2 reset = 1'b1;
    #1;
    check_eq("t6_req_async", 64'(Req), 64'd0);
    check_eq("t6_pstate_async", 64'(dut.pstate_q), 64'd0);
    check_eq("t6_memindex_async", 64'(dut.mem_index_q), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    push_txn(7'b0011101, 32'h200, 32'h12345678);
    Ready = 1'b1;
    pulse_en();
    wait_idle("t6_done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
